// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU class encodings and main-control decode
// used by the instruction-decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_RTYPE = 3'd2,
    ALU_AND   = 3'd3,
    ALU_OR    = 3'd4,
    ALU_SLT   = 3'd5,
    ALU_LUI   = 3'd6
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    logic    branch_eq;
    logic    branch_ne;
    logic    is_jump;
    logic    illegal;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    // NOTE: start from an all-zero default so every field is assigned on every path.
    c = CTRL_BUBBLE;
    case (opcode)
      OP_RTYPE: begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.alu_op = ALU_RTYPE; end
      OP_LW:    begin c.reg_write = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.alu_src = 1'b1; end
      OP_SW:    begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BEQ:   begin c.branch_eq = 1'b1; c.alu_op = ALU_SUB; end
      OP_BNE:   begin c.branch_ne = 1'b1; c.alu_op = ALU_SUB; end
      OP_J:     c.is_jump = 1'b1;
      OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_SLTI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SLT; end
      OP_ANDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
      OP_ORI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR; end
      OP_LUI:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_LUI; end
      default:  c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] extend_imm(input logic [5:0] opcode, input logic [15:0] imm16);
    case (opcode)
      OP_ANDI, OP_ORI: return {16'h0000, imm16};
      OP_LUI:          return {imm16, 16'h0000};
      default:         return {{16{imm16[15]}}, imm16};
    endcase
  endfunction

  // Opcodes that read rt as an operand rather than writing it.
  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write register file with a hardwired zero register and an
// optional same-cycle writeback bypass onto the read ports.
module register_file #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_live;

  assign write_live = write_enable && (write_addr != '0);

  // NOTE: the whole array is cleared on reset, so this maps to flops, not a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (write_live) begin
      regs[write_addr] <= write_data;
    end
  end

  assign rs_data = (rs_addr == '0) ? '0
                 : (BYPASS && write_live && (write_addr == rs_addr)) ? write_data
                 : regs[rs_addr];

  assign rt_data = (rt_addr == '0) ? '0
                 : (BYPASS && write_live && (write_addr == rt_addr)) ? write_data
                 : regs[rt_addr];

endmodule

// File: rtl/stage_id.sv
// Instruction-decode stage: IF/ID latch, register file, main control decode,
// load-use hazard detection and the ID/EX register feeding execute.
module stage_id #(
  parameter int          REG_ADDR_WIDTH = 5,
  parameter bit          WB_BYPASS      = 1'b1,
  parameter logic [31:0] NOP_WORD       = mips_pkg::NOP_WORD
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               if_instruction,
  input  logic [31:0]               if_pc_next,
  input  logic                      control_flush,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [31:0]               wb_write_data,
  output logic                      control_stall,
  output logic [31:0]               data_pc_next,
  output logic [31:0]               data_rs_value,
  output logic [31:0]               data_rt_value,
  output logic [31:0]               data_imm_ext,
  output logic [REG_ADDR_WIDTH-1:0] data_rs,
  output logic [REG_ADDR_WIDTH-1:0] data_rt,
  output logic [REG_ADDR_WIDTH-1:0] data_rd,
  output logic [4:0]                data_shamt,
  output logic [5:0]                data_funct,
  output logic [31:0]               data_branch_address,
  output logic [31:0]               data_jump_address,
  output logic                      control_reg_write,
  output logic                      control_mem_read,
  output logic                      control_mem_write,
  output logic                      control_mem_to_reg,
  output logic                      control_alu_src,
  output logic                      control_reg_dst,
  output logic                      control_branch_eq,
  output logic                      control_branch_ne,
  output logic                      control_is_jump,
  output logic [2:0]                control_alu_op,
  output logic                      control_illegal
);

  import mips_pkg::*;

  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_next;

  logic [5:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] id_rs, id_rt, id_rd;
  logic [4:0]                id_shamt;
  logic [5:0]                id_funct;
  logic [15:0]               id_imm16;
  logic [25:0]               id_target;

  ctrl_t       dec_ctrl;
  ctrl_t       idex_ctrl;
  logic [31:0] imm_ext;
  logic [31:0] rs_value, rt_value;

  assign opcode    = ifid_instr[31:26];
  assign id_rs     = ifid_instr[25:21];
  assign id_rt     = ifid_instr[20:16];
  assign id_rd     = ifid_instr[15:11];
  assign id_shamt  = ifid_instr[10:6];
  assign id_funct  = ifid_instr[5:0];
  assign id_imm16  = ifid_instr[15:0];
  assign id_target = ifid_instr[25:0];

  assign dec_ctrl = decode_ctrl(opcode);
  assign imm_ext  = extend_imm(opcode, id_imm16);

  register_file #(
    .ADDR_WIDTH (REG_ADDR_WIDTH),
    .DATA_WIDTH (32),
    .BYPASS     (WB_BYPASS)
  ) u_register_file (
    .clock        (clock),
    .reset        (reset),
    .rs_addr      (id_rs),
    .rt_addr      (id_rt),
    .write_enable (wb_reg_write),
    .write_addr   (wb_write_reg),
    .write_data   (wb_write_data),
    .rs_data      (rs_value),
    .rt_data      (rt_value)
  );

  // A load in EX whose destination feeds the instruction in ID must wait one cycle.
  assign control_stall = idex_ctrl.mem_read && (data_rt != '0) &&
                         ((data_rt == id_rs) || ((data_rt == id_rt) && uses_rt(opcode)));

  // NOTE: all pipeline state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || control_flush) begin
      ifid_instr   <= NOP_WORD;
      ifid_pc_next <= '0;
    end else if (!control_stall) begin
      ifid_instr   <= if_instruction;
      ifid_pc_next <= if_pc_next;
    end
  end

  // Reset, flush and stall all leave a zeroed bubble in ID/EX.
  always_ff @(posedge clock) begin
    if (reset || control_flush || control_stall) begin
      idex_ctrl           <= CTRL_BUBBLE;
      data_pc_next        <= '0;
      data_rs_value       <= '0;
      data_rt_value       <= '0;
      data_imm_ext        <= '0;
      data_rs             <= '0;
      data_rt             <= '0;
      data_rd             <= '0;
      data_shamt          <= '0;
      data_funct          <= '0;
      data_branch_address <= '0;
      data_jump_address   <= '0;
    end else begin
      idex_ctrl           <= dec_ctrl;
      data_pc_next        <= ifid_pc_next;
      data_rs_value       <= rs_value;
      data_rt_value       <= rt_value;
      data_imm_ext        <= imm_ext;
      data_rs             <= id_rs;
      data_rt             <= id_rt;
      data_rd             <= id_rd;
      data_shamt          <= id_shamt;
      data_funct          <= id_funct;
      data_branch_address <= ifid_pc_next + (imm_ext << 2);
      data_jump_address   <= {ifid_pc_next[31:28], id_target, 2'b00};
    end
  end

  assign control_reg_write  = idex_ctrl.reg_write;
  assign control_mem_read   = idex_ctrl.mem_read;
  assign control_mem_write  = idex_ctrl.mem_write;
  assign control_mem_to_reg = idex_ctrl.mem_to_reg;
  assign control_alu_src    = idex_ctrl.alu_src;
  assign control_reg_dst    = idex_ctrl.reg_dst;
  assign control_branch_eq  = idex_ctrl.branch_eq;
  assign control_branch_ne  = idex_ctrl.branch_ne;
  assign control_is_jump    = idex_ctrl.is_jump;
  assign control_illegal    = idex_ctrl.illegal;
  assign control_alu_op     = idex_ctrl.alu_op;

endmodule

// File: tb/tb_stage_id.sv
// Directed-vector bench for stage_id: decode, extension, targets, regfile bypass,
// load-use stall, flush-over-stall and reset-over-stall.
module tb_stage_id;

  logic        clock;
  logic        reset;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_next;
  logic        control_flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        control_stall;
  logic [31:0] data_pc_next, data_rs_value, data_rt_value, data_imm_ext;
  logic [4:0]  data_rs, data_rt, data_rd, data_shamt;
  logic [5:0]  data_funct;
  logic [31:0] data_branch_address, data_jump_address;
  logic        control_reg_write, control_mem_read, control_mem_write, control_mem_to_reg;
  logic        control_alu_src, control_reg_dst, control_branch_eq, control_branch_ne;
  logic        control_is_jump, control_illegal;
  logic [2:0]  control_alu_op;

  int n_vec = 0;
  int n_err = 0;

  // {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, beq, bne, jump, illegal, alu_op[2:0]}
  logic [12:0] ctrl_obs;
  assign ctrl_obs = {control_reg_write, control_mem_read, control_mem_write, control_mem_to_reg,
                     control_alu_src, control_reg_dst, control_branch_eq, control_branch_ne,
                     control_is_jump, control_illegal, control_alu_op};

  localparam logic [12:0] C_NONE  = 13'b0_0_0_0_0_0_0_0_0_0_000;
  localparam logic [12:0] C_RTYPE = 13'b1_0_0_0_0_1_0_0_0_0_010;
  localparam logic [12:0] C_LW    = 13'b1_1_0_1_1_0_0_0_0_0_000;
  localparam logic [12:0] C_ADDI  = 13'b1_0_0_0_1_0_0_0_0_0_000;
  localparam logic [12:0] C_BEQ   = 13'b0_0_0_0_0_0_1_0_0_0_001;

  localparam logic [31:0] I_NOP = 32'h0000_0000;
  localparam logic [31:0] I_LW  = 32'h8C22_0004;  // lw  $2,4($1)
  localparam logic [31:0] I_ADD = 32'h0042_1820;  // add $3,$2,$2

  stage_id u_dut (
    .clock               (clock),
    .reset               (reset),
    .if_instruction      (if_instruction),
    .if_pc_next          (if_pc_next),
    .control_flush       (control_flush),
    .wb_reg_write        (wb_reg_write),
    .wb_write_reg        (wb_write_reg),
    .wb_write_data       (wb_write_data),
    .control_stall       (control_stall),
    .data_pc_next        (data_pc_next),
    .data_rs_value       (data_rs_value),
    .data_rt_value       (data_rt_value),
    .data_imm_ext        (data_imm_ext),
    .data_rs             (data_rs),
    .data_rt             (data_rt),
    .data_rd             (data_rd),
    .data_shamt          (data_shamt),
    .data_funct          (data_funct),
    .data_branch_address (data_branch_address),
    .data_jump_address   (data_jump_address),
    .control_reg_write   (control_reg_write),
    .control_mem_read    (control_mem_read),
    .control_mem_write   (control_mem_write),
    .control_mem_to_reg  (control_mem_to_reg),
    .control_alu_src     (control_alu_src),
    .control_reg_dst     (control_reg_dst),
    .control_branch_eq   (control_branch_eq),
    .control_branch_ne   (control_branch_ne),
    .control_is_jump     (control_is_jump),
    .control_alu_op      (control_alu_op),
    .control_illegal     (control_illegal)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [12:0] ctrl;
    logic [31:0] imm;
    logic [31:0] branch;
    logic [31:0] jump;
    logic [31:0] rs_value;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present one word for one edge, then fall back to NOP.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    if_instruction = instr;
    if_pc_next     = pc;
    tick();
    if_instruction = I_NOP;
    if_pc_next     = 32'h0;
  endtask

  initial begin
    vecs[0] = '{"ori",   32'h3404_8001, 32'h0000_0100, 13'b1_0_0_0_1_0_0_0_0_0_100,
                32'h0000_8001, 32'h0002_0104, 32'h0012_0004, 32'h0000_0000};
    vecs[1] = '{"lui",   32'h3C04_1234, 32'h0000_0100, 13'b1_0_0_0_1_0_0_0_0_0_110,
                32'h1234_0000, 32'h48D0_0100, 32'h0010_48D0, 32'h0000_0000};
    vecs[2] = '{"j",     32'h0BFF_FFFF, 32'hA000_0010, 13'b0_0_0_0_0_0_0_0_1_0_000,
                32'hFFFF_FFFF, 32'hA000_000C, 32'hAFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{"bne",   32'h1422_0004, 32'hFFFF_FFFC, 13'b0_0_0_0_0_0_0_1_0_0_001,
                32'h0000_0004, 32'h0000_000C, 32'hF088_0010, 32'h0000_0010};
    vecs[4] = '{"sw",    32'hAC22_FFF8, 32'h0000_0040, 13'b0_0_1_0_1_0_0_0_0_0_000,
                32'hFFFF_FFF8, 32'h0000_0020, 32'h008B_FFE0, 32'h0000_0010};
    vecs[5] = '{"slti",  32'h2823_FFFF, 32'h0000_0008, 13'b1_0_0_0_1_0_0_0_0_0_101,
                32'hFFFF_FFFF, 32'h0000_0004, 32'h008F_FFFC, 32'h0000_0010};
    vecs[6] = '{"andi",  32'h3023_FFFF, 32'h0000_0008, 13'b1_0_0_0_1_0_0_0_0_0_011,
                32'h0000_FFFF, 32'h0004_0004, 32'h008F_FFFC, 32'h0000_0010};
    vecs[7] = '{"illeg", 32'hFC22_1234, 32'h0000_0010, 13'b0_0_0_0_0_0_0_0_0_1_000,
                32'h0000_1234, 32'h0000_48E0, 32'h0088_48D0, 32'h0000_0010};

    reset          = 1'b1;
    if_instruction = I_NOP;
    if_pc_next     = 32'h0;
    control_flush  = 1'b0;
    wb_reg_write   = 1'b0;
    wb_write_reg   = 5'd0;
    wb_write_data  = 32'h0;
    tick();
    tick();

    check("rst_stall", 32'(control_stall), 32'd0);
    check("rst_ctrl",  32'(ctrl_obs), 32'(C_NONE));
    check("rst_pc",    data_pc_next, 32'h0);
    check("rst_imm",   data_imm_ext, 32'h0);

    // Preload $1 = 0x10.
    reset         = 1'b0;
    wb_reg_write  = 1'b1;
    wb_write_reg  = 5'd1;
    wb_write_data = 32'h0000_0010;
    tick();
    wb_reg_write  = 1'b0;

    // lw $2,4($1): visible on ID/EX two edges after it is presented.
    issue(I_LW, 32'h0000_0104);
    check("lw_nostall", 32'(control_stall), 32'd0);
    tick();
    check("lw_ctrl",   32'(ctrl_obs), 32'(C_LW));
    check("lw_imm",    data_imm_ext, 32'h0000_0004);
    check("lw_rsval",  data_rs_value, 32'h0000_0010);
    check("lw_rt",     32'(data_rt), 32'd2);
    check("lw_pc",     data_pc_next, 32'h0000_0104);
    check("lw_br",     data_branch_address, 32'h0000_0114);

    // Load-use: lw $2 then add $3,$2,$2.
    if_instruction = I_LW;  if_pc_next = 32'h0000_0200;
    tick();
    if_instruction = I_ADD; if_pc_next = 32'h0000_0204;
    tick();
    check("lu_stall", 32'(control_stall), 32'd1);
    tick();
    check("lu_stall_end",   32'(control_stall), 32'd0);
    check("lu_bubble_ctrl", 32'(ctrl_obs), 32'(C_NONE));
    check("lu_bubble_rs",   32'(data_rs), 32'd0);
    if_instruction = I_NOP; if_pc_next = 32'h0;
    tick();
    check("add_ctrl",  32'(ctrl_obs), 32'(C_RTYPE));
    check("add_rs",    32'(data_rs), 32'd2);
    check("add_rt",    32'(data_rt), 32'd2);
    check("add_rd",    32'(data_rd), 32'd3);
    check("add_funct", 32'(data_funct), 32'h20);
    check("add_pc",    data_pc_next, 32'h0000_0204);

    // Same-cycle writeback bypass: addi $6,$5,1 sits in ID while $5 is written.
    issue(32'h20A6_0001, 32'h0000_0300);
    wb_reg_write  = 1'b1;
    wb_write_reg  = 5'd5;
    wb_write_data = 32'hDEAD_BEEF;
    tick();
    check("byp_rsval", data_rs_value, 32'hDEAD_BEEF);
    check("byp_ctrl",  32'(ctrl_obs), 32'(C_ADDI));
    check("byp_imm",   data_imm_ext, 32'h0000_0001);

    // Write to $0 is dropped; add $2,$0,$5 then reads $0=0 and stored $5.
    if_instruction = 32'h0005_1020;
    wb_write_reg   = 5'd0;
    wb_write_data  = 32'h1234_5678;
    tick();
    wb_reg_write   = 1'b0;
    if_instruction = I_NOP;
    tick();
    check("r0_rsval", data_rs_value, 32'h0);
    check("r5_rtval", data_rt_value, 32'hDEAD_BEEF);

    // beq $1,$2,-1 with pc_next 8: target wraps back to 4.
    issue(32'h1022_FFFF, 32'h0000_0008);
    tick();
    check("beq_imm",   data_imm_ext, 32'hFFFF_FFFF);
    check("beq_br",    data_branch_address, 32'h0000_0004);
    check("beq_ctrl",  32'(ctrl_obs), 32'(C_BEQ));
    check("beq_rsval", data_rs_value, 32'h0000_0010);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].instr, vecs[i].pc);
      tick();
      check({vecs[i].tag, "_ctrl"},  32'(ctrl_obs), 32'(vecs[i].ctrl));
      check({vecs[i].tag, "_imm"},   data_imm_ext, vecs[i].imm);
      check({vecs[i].tag, "_br"},    data_branch_address, vecs[i].branch);
      check({vecs[i].tag, "_jmp"},   data_jump_address, vecs[i].jump);
      check({vecs[i].tag, "_rsval"}, data_rs_value, vecs[i].rs_value);
    end

    // Flush while a load-use stall is pending.
    if_instruction = I_LW;  if_pc_next = 32'h0000_0400;
    tick();
    if_instruction = I_ADD; if_pc_next = 32'h0000_0404;
    tick();
    check("fl_stall_pre", 32'(control_stall), 32'd1);
    control_flush = 1'b1;
    tick();
    control_flush = 1'b0;
    check("fl_stall_post", 32'(control_stall), 32'd0);
    check("fl_ctrl",       32'(ctrl_obs), 32'(C_NONE));
    if_instruction = I_NOP; if_pc_next = 32'h0;
    tick();
    check("fl_ifid_ctrl", 32'(ctrl_obs), 32'(C_RTYPE));
    check("fl_ifid_rd",   32'(data_rd), 32'd0);
    check("fl_ifid_rt",   32'(data_rt), 32'd0);

    // Reset while a load-use stall is pending.
    if_instruction = I_LW;  if_pc_next = 32'h0000_0500;
    tick();
    if_instruction = I_ADD; if_pc_next = 32'h0000_0504;
    tick();
    check("rs_stall_pre", 32'(control_stall), 32'd1);
    reset = 1'b1;
    tick();
    check("rs_stall_post", 32'(control_stall), 32'd0);
    check("rs_ctrl",       32'(ctrl_obs), 32'(C_NONE));
    check("rs_pc",         data_pc_next, 32'h0);
    check("rs_rt",         32'(data_rt), 32'd0);
    reset          = 1'b0;
    if_instruction = 32'h2026_0000;  // addi $6,$1,0
    if_pc_next     = 32'h0000_0508;
    tick();
    check("rs_ifid_nop", 32'(ctrl_obs), 32'(C_RTYPE));
    if_instruction = I_NOP; if_pc_next = 32'h0;
    tick();
    check("rs_addi_ctrl",  32'(ctrl_obs), 32'(C_ADDI));
    check("rs_addi_rs",    32'(data_rs), 32'd1);
    check("rs_regs_clear", data_rs_value, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
